pc_redirect_ctrl: RTL and testbench



---
 rtl/pc_ctrl_pkg.sv | 22 ++
 rtl/redirect_prio_sel.sv | 41 ++++
 rtl/pc_redirect_ctrl.sv | 148 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-PC redirect controller: FSM states, redirect causes
// (encoded so that numeric order equals priority) and the default reset vector.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD,
        S_FLUSH
    } state_e;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_JMP  = 3'd1,
        C_BR   = 3'd2,
        C_MRET = 3'd3,
        C_TRAP = 3'd4
    } cause_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0;

endpackage

// File: rtl/redirect_prio_sel.sv
// Combinational 4-way redirect priority mux: trap > mret > br > jmp.
module redirect_prio_sel
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mret_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    output logic            valid,
    output cause_e          cause,
    output logic [XLEN-1:0] target
);

    always_comb begin
        valid  = 1'b1;
        cause  = C_NONE;
        target = '0;
        if (trap_valid) begin
            cause  = C_TRAP;
            target = trap_vec;
        end else if (mret_valid) begin
            cause  = C_MRET;
            target = mret_pc;
        end else if (br_valid) begin
            cause  = C_BR;
            target = br_target;
        end else if (jmp_valid) begin
            cause  = C_JMP;
            target = jmp_target;
        end else begin
            valid  = 1'b0;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: arbitrates redirects and back-pressure into npc/npc_en/stall_en,
// parks a redirect while fetch is busy, and opens a flush window after each redirect.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VEC    = XLEN'(DEFAULT_RESET_VEC),
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_trap_valid,
    input  logic [XLEN-1:0] io_trap_vec,
    input  logic            io_mret_valid,
    input  logic [XLEN-1:0] io_mret_pc,
    input  logic            io_br_valid,
    input  logic [XLEN-1:0] io_br_target,
    input  logic            io_jmp_valid,
    input  logic [XLEN-1:0] io_jmp_target,
    input  logic            io_hazard_stall,
    input  logic            io_fetch_ready,
    output logic [XLEN-1:0] io_npc,
    output logic            io_npc_en,
    output logic            io_stall_en,
    output logic            io_flush,
    output logic            io_busy
);

    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam state_e      AFTER_REDIRECT = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
    localparam logic [CW-1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 1) : '0;

    state_e          state;
    logic [XLEN-1:0] pend_tgt;
    cause_e          pend_cause;
    logic [CW-1:0]   flush_cnt;

    logic            sel_valid;
    cause_e          sel_cause;
    logic [XLEN-1:0] sel_target;
    logic            in_flush;
    logic            take_new;
    logic [XLEN-1:0] hold_tgt;
    cause_e          hold_cause;

    // Inside the flush window only a trap is live; the others come from squashed instructions.
    assign in_flush = (state == S_FLUSH);

    redirect_prio_sel #(
        .XLEN(XLEN)
    ) u_prio_sel (
        .trap_valid (io_trap_valid),
        .trap_vec   (io_trap_vec),
        .mret_valid (io_mret_valid & ~in_flush),
        .mret_pc    (io_mret_pc),
        .br_valid   (io_br_valid & ~in_flush),
        .br_target  (io_br_target),
        .jmp_valid  (io_jmp_valid & ~in_flush),
        .jmp_target (io_jmp_target),
        .valid      (sel_valid),
        .cause      (sel_cause),
        .target     (sel_target)
    );

    assign take_new   = sel_valid && (sel_cause >= pend_cause);
    assign hold_tgt   = take_new ? sel_target : pend_tgt;
    assign hold_cause = take_new ? sel_cause  : pend_cause;

    always_comb begin
        io_npc      = '0;
        io_npc_en   = 1'b0;
        io_stall_en = 1'b0;
        io_flush    = 1'b0;
        io_busy     = (state != S_RUN);
        case (state)
            S_BOOT: begin
                io_npc    = RESET_VEC;
                io_npc_en = 1'b1;
                io_flush  = 1'b1;
            end
            S_RUN, S_FLUSH: begin
                io_flush = in_flush | sel_valid;
                if (sel_valid) begin
                    if (io_fetch_ready) begin
                        io_npc    = sel_target;
                        io_npc_en = 1'b1;
                    end else begin
                        io_stall_en = 1'b1;
                    end
                end else begin
                    io_stall_en = io_hazard_stall | ~io_fetch_ready;
                end
            end
            S_HOLD: begin
                io_flush = 1'b1;
                if (io_fetch_ready) begin
                    io_npc    = hold_tgt;
                    io_npc_en = 1'b1;
                end else begin
                    io_stall_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_BOOT;
            pend_tgt   <= '0;
            pend_cause <= C_NONE;
            flush_cnt  <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN, S_FLUSH: begin
                    if (sel_valid) begin
                        if (io_fetch_ready) begin
                            state     <= AFTER_REDIRECT;
                            flush_cnt <= FLUSH_RELOAD;
                        end else begin
                            state      <= S_HOLD;
                            pend_tgt   <= sel_target;
                            pend_cause <= sel_cause;
                            flush_cnt  <= '0;
                        end
                    end else if (in_flush) begin
                        flush_cnt <= flush_cnt - CW'(1);
                        if (flush_cnt == CW'(1)) state <= S_RUN;
                    end
                end
                S_HOLD: begin
                    if (io_fetch_ready) begin
                        state      <= AFTER_REDIRECT;
                        flush_cnt  <= FLUSH_RELOAD;
                        pend_tgt   <= '0;
                        pend_cause <= C_NONE;
                    end else begin
                        pend_tgt   <= hold_tgt;
                        pend_cause <= hold_cause;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic,
// expectations from a cycle-level reference model of the redirect rules.
module tb_pc_redirect_ctrl;

    localparam int unsigned    FC = 2;
    localparam logic [31:0]    RV = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_valid, mret_valid, br_valid, jmp_valid;
    logic [31:0] trap_vec, mret_pc, br_target, jmp_target;
    logic        hazard, ready;
    logic [31:0] npc;
    logic        npc_en, stall_en, flush, busy;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .XLEN        (32),
        .RESET_VEC   (RV),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clock          (clk),
        .reset          (rst_n),
        .io_trap_valid  (trap_valid),
        .io_trap_vec    (trap_vec),
        .io_mret_valid  (mret_valid),
        .io_mret_pc     (mret_pc),
        .io_br_valid    (br_valid),
        .io_br_target   (br_target),
        .io_jmp_valid   (jmp_valid),
        .io_jmp_target  (jmp_target),
        .io_hazard_stall(hazard),
        .io_fetch_ready (ready),
        .io_npc         (npc),
        .io_npc_en      (npc_en),
        .io_stall_en    (stall_en),
        .io_flush       (flush),
        .io_busy        (busy)
    );

    typedef struct {
        logic        rst;
        logic        trap, mret, br, jmp;
        logic [31:0] tv, mp, bt, jt;
        logic        haz, rdy;
    } stim_t;

    typedef struct {
        logic [31:0] npc;
        logic        en, stall, flush, busy;
    } exp_t;

    stim_t s;
    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state: boot pending, parked redirect, remaining flush cycles.
    bit          m_boot = 1'b1;
    bit          m_has_pend = 1'b0;
    logic [31:0] m_pend_tgt = '0;
    int          m_pend_pri = 0;
    int          m_flush_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("npc",      npc,             e.npc);
            chk("npc_en",   32'(npc_en),     32'(e.en));
            chk("stall_en", 32'(stall_en),   32'(e.stall));
            chk("flush",    32'(flush),      32'(e.flush));
            chk("busy",     32'(busy),       32'(e.busy));
        end
    end

    function automatic exp_t model(input stim_t x);
        exp_t        e;
        int          rp = 0;
        logic [31:0] rt = '0;
        bit          in_fl;
        e = '{npc: '0, en: 1'b0, stall: 1'b0, flush: 1'b0, busy: 1'b0};
        if (!x.rst) begin
            m_boot = 1; m_has_pend = 0; m_pend_tgt = '0; m_pend_pri = 0; m_flush_left = 0;
            return '{npc: RV, en: 1'b1, stall: 1'b0, flush: 1'b1, busy: 1'b1};
        end
        if (m_boot) begin
            m_boot = 0;
            return '{npc: RV, en: 1'b1, stall: 1'b0, flush: 1'b1, busy: 1'b1};
        end
        in_fl = (m_flush_left > 0);
        if (!in_fl && x.jmp)  begin rp = 1; rt = x.jt; end
        if (!in_fl && x.br)   begin rp = 2; rt = x.bt; end
        if (!in_fl && x.mret) begin rp = 3; rt = x.mp; end
        if (x.trap)           begin rp = 4; rt = x.tv; end
        if (m_has_pend) begin
            e.busy  = 1;
            e.flush = 1;
            if (rp != 0 && rp >= m_pend_pri) begin m_pend_pri = rp; m_pend_tgt = rt; end
            if (x.rdy) begin
                e.en = 1; e.npc = m_pend_tgt;
                m_has_pend = 0; m_pend_pri = 0; m_pend_tgt = '0;
                m_flush_left = FC - 1;
            end else begin
                e.stall = 1;
            end
        end else begin
            e.busy = in_fl;
            if (rp != 0) begin
                e.flush = 1;
                if (x.rdy) begin
                    e.en = 1; e.npc = rt;
                    m_flush_left = FC - 1;
                end else begin
                    e.stall = 1;
                    m_has_pend = 1; m_pend_pri = rp; m_pend_tgt = rt;
                    m_flush_left = 0;
                end
            end else begin
                e.flush = in_fl;
                e.stall = x.haz | ~x.rdy;
                if (in_fl) m_flush_left--;
            end
        end
        return e;
    endfunction

    task automatic apply();
        rst_n = s.rst;
        trap_valid = s.trap; trap_vec = s.tv;
        mret_valid = s.mret; mret_pc = s.mp;
        br_valid = s.br; br_target = s.bt;
        jmp_valid = s.jmp; jmp_target = s.jt;
        hazard = s.haz; ready = s.rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply();
        q.push_back(model(s));
    endtask

    task automatic idle();
        s.rst = 1; s.trap = 0; s.mret = 0; s.br = 0; s.jmp = 0;
        s.tv = '0; s.mp = '0; s.bt = '0; s.jt = '0;
        s.haz = 0; s.rdy = 1;
    endtask

    initial begin
        idle();
        s.rst = 0;
        apply();

        // Reset sequence and boot load
        repeat (3) step();
        idle(); repeat (3) step();

        // Branch redirect with fetch ready, then flush window
        s.br = 1; s.bt = 32'h40; step();
        idle(); repeat (3) step();

        // Simultaneous jump and trap
        s.jmp = 1; s.jt = 32'h80; s.trap = 1; s.tv = 32'h100; step();
        idle(); repeat (3) step();

        // Branch parked while fetch stalls, overwritten by a trap
        s.br = 1; s.bt = 32'h200; s.rdy = 0; step();
        idle(); s.rdy = 0; s.trap = 1; s.tv = 32'h300; step();
        idle(); s.rdy = 0; step();
        idle(); repeat (3) step();

        // Branch ignored inside the flush window, trap honoured there
        s.jmp = 1; s.jt = 32'h10; step();
        idle(); s.br = 1; s.bt = 32'h500; step();
        idle(); s.jmp = 1; s.jt = 32'h20; step();
        idle(); s.trap = 1; s.tv = 32'h600; step();
        idle(); repeat (3) step();

        // Reset while a redirect is parked
        s.br = 1; s.bt = 32'h700; s.rdy = 0; step();
        idle(); s.rdy = 0; step();
        idle(); s.rst = 0; s.rdy = 0; step();
        idle(); repeat (4) step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 79) != 0);
            s.trap = ($urandom_range(0, 9) == 0);
            s.mret = ($urandom_range(0, 9) == 0);
            s.br   = ($urandom_range(0, 5) == 0);
            s.jmp  = ($urandom_range(0, 5) == 0);
            s.tv = $urandom; s.mp = $urandom; s.bt = $urandom; s.jt = $urandom;
            s.haz  = ($urandom_range(0, 3) == 0);
            s.rdy  = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(); repeat (3) step();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
